// File: rtl/mul_pkg.sv
// Shared types for the EX-stage sequential multiplier.
// Op encodings follow the RV64M MUL/MULH/MULHSU/MULHU order.
package mul_pkg;

  localparam int MUL_WIDTH = 64;

  typedef enum logic [1:0] {
    MUL_LO  = 2'd0,
    MUL_HSS = 2'd1,
    MUL_HSU = 2'd2,
    MUL_HUU = 2'd3
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mul_state_e;

endpackage

// File: rtl/seq_multiplier_if.sv
// Operand/result handshake bundle between EX stage and multiplier.
// master = EX stage side, slave = multiplier side.
interface seq_multiplier_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;

  modport master (
    output in_valid, op, a, b, flush, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, op, a, b, flush, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/seq_multiplier_cond_negate.sv
// Conditional two's-complement negation.
// Used for operand magnitudes and the final product sign fix.
module cond_negate #(
  parameter int W = 64
) (
  input  logic [W-1:0] in_i,
  input  logic         neg_i,
  output logic [W-1:0] out_o
);

  assign out_o = neg_i ? (~in_i + W'(1)) : in_i;

endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier for RV64M MUL/MULH/MULHSU/MULHU.
// One iteration per cycle, fixed latency, one operation in flight.
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input logic              clock,
  input logic              reset_n,
  seq_multiplier_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  mul_state_e       state_q, state_d;
  mul_op_e          op_q, op_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] res_q, res_d;

  logic             sa_used;
  logic             sb_used;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]   sum;

  assign sa_used = (bus.op == MUL_HSS || bus.op == MUL_HSU)
                 && bus.a[WIDTH-1];
  assign sb_used = (bus.op == MUL_HSS) && bus.b[WIDTH-1];

  cond_negate #(.W(WIDTH)) u_neg_a (
    .in_i  (bus.a),
    .neg_i (sa_used),
    .out_o (abs_a)
  );

  cond_negate #(.W(WIDTH)) u_neg_b (
    .in_i  (bus.b),
    .neg_i (sb_used),
    .out_o (abs_b)
  );

  cond_negate #(.W(2*WIDTH)) u_neg_p (
    .in_i  (acc_q),
    .neg_i (neg_q),
    .out_o (prod)
  );

  // Carry bit of the upper-half add shifts down into the accumulator MSB
  assign sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
             + {1'b0, (mplier_q[0] ? mcand_q : '0)};

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    res_d    = res_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && !bus.flush) begin
          state_d  = CALC;
          op_d     = mul_op_e'(bus.op);
          mcand_d  = abs_a;
          mplier_d = abs_b;
          neg_d    = sa_used ^ sb_used;
          acc_d    = '0;
          cnt_d    = CW'(WIDTH-1);
        end
      end
      CALC: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          acc_d    = {sum, acc_q[WIDTH-1:1]};
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q - CW'(1);
          if (cnt_q == '0) state_d = FIX;
        end
      end
      FIX: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          res_d   = (op_q == MUL_LO) ? prod[WIDTH-1:0]
                                     : prod[2*WIDTH-1:WIDTH];
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.flush || bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      op_q     <= MUL_LO;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      res_q    <= res_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = res_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed-vector bench for seq_multiplier.
// Expected values are hand-computed products.
module tb_seq_multiplier;
  import mul_pkg::*;

  localparam int W = 64;
  localparam logic [W-1:0] MIN  = 64'h8000_0000_0000_0000;
  localparam logic [W-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clock;
  logic reset_n;
  int   n_chk;
  int   n_fail;

  seq_multiplier_if #(.WIDTH(W)) bus ();

  seq_multiplier #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic accept(input logic [1:0] op,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    bus.op       = 2'd0;
    bus.a        = '0;
    bus.b        = '0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!bus.out_valid && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
  endtask

  task automatic run(input string tag,
                     input logic [1:0] op,
                     input logic [W-1:0] a,
                     input logic [W-1:0] b,
                     input logic [W-1:0] exp);
    int n;
    accept(op, a, b);
    chk({tag, "_busy"}, W'(bus.in_ready), '0);
    wait_done(n);
    chk({tag, "_lat"}, W'(n), W'(65));
    chk({tag, "_res"}, bus.result, exp);
    if (bus.out_ready) begin
      @(posedge clock); #1;
      chk({tag, "_rdy"}, W'(bus.in_ready), W'(1));
      chk({tag, "_ovl"}, W'(bus.out_valid), '0);
    end
  endtask

  initial begin
    int n;
    int seen;
    n_chk  = 0;
    n_fail = 0;
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = 2'd0;
    bus.a         = '0;
    bus.b         = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_rdy", W'(bus.in_ready), W'(1));
    chk("rst_ovl", W'(bus.out_valid), '0);
    chk("rst_res", bus.result, '0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    run("mul_3x5", MUL_LO, 64'd3, 64'd5, 64'd15);
    run("mulh_min", MUL_HSS, MIN, MIN, 64'h4000_0000_0000_0000);
    run("mulh_m1", MUL_HSS, ONES, ONES, 64'd0);
    run("mulhu_ff", MUL_HUU, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE);
    run("mul_ff", MUL_LO, ONES, ONES, 64'd1);
    run("mulh_mix", MUL_HSS, ONES, 64'd5, ONES);
    run("mulhsu_min", MUL_HSU, MIN, 64'd2, ONES);

    // Result held while consumer stalls
    bus.out_ready = 1'b0;
    run("mulhsu", MUL_HSU, ONES, ONES, ONES);
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      chk("hold_ovl", W'(bus.out_valid), W'(1));
      chk("hold_res", bus.result, ONES);
      chk("hold_rdy", W'(bus.in_ready), '0);
    end
    bus.out_ready = 1'b1;
    @(posedge clock); #1;
    chk("hold_rel", W'(bus.in_ready), W'(1));

    // Flush mid-CALC
    accept(MUL_HUU, 64'd9, 64'd9);
    repeat (19) @(posedge clock);
    #1;
    bus.flush = 1'b1;
    @(posedge clock); #1;
    bus.flush = 1'b0;
    chk("fl_rdy", W'(bus.in_ready), W'(1));
    chk("fl_ovl", W'(bus.out_valid), '0);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.op       = MUL_LO;
    bus.a        = 64'd4;
    bus.b        = 64'd4;
    @(posedge clock); #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl_idle", W'(bus.in_ready), W'(1));
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clock); #1;
      if (bus.out_valid || !bus.in_ready) seen++;
    end
    chk("fl_quiet", W'(seen), '0);
    run("fl_next", MUL_LO, 64'd7, 64'd6, 64'd42);

    // Async reset mid-CALC
    accept(MUL_HUU, ONES, ONES);
    repeat (10) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    chk("ar_rdy", W'(bus.in_ready), W'(1));
    chk("ar_ovl", W'(bus.out_valid), '0);
    chk("ar_res", bus.result, '0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    run("ar_mulhu", MUL_HUU, 64'd2, 64'd3, 64'd0);
    run("ar_mul", MUL_LO, 64'd2, 64'd3, 64'd6);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
